// File: rtl/fx_conv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fx_conv_pkg : shared types and constants for the float-to-fixed    |
// | converter family.                                   Revision: 1.0  |
// +--------------------------------------------------------------------+
package fx_conv_pkg;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } fp_class_e;

  localparam int FLAG_INX = 0;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_INV = 3;

  localparam logic RND_TRUNC = 1'b0;
  localparam logic RND_RNE   = 1'b1;

  function automatic int fp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fx_align_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fx_align_shifter : signed-amount bidirectional aligner returning   |
// | the shifted magnitude plus guard, sticky and lost bits. Rev: 1.0   |
// +--------------------------------------------------------------------+
module fx_align_shifter #(
  parameter int IW  = 24,
  parameter int OW  = 33,
  parameter int SHW = 10
) (
  input  logic [IW-1:0]         mag_i,
  input  logic signed [SHW-1:0] sh_i,
  output logic [OW-1:0]         mag_o,
  output logic                  guard_o,
  output logic                  sticky_o,
  output logic                  lost_o
);

  localparam int LW = OW + IW;
  localparam int RW = 2 * IW + 1;

  logic [SHW-1:0] amt;
  logic [LW-1:0]  left_v;
  logic [RW-1:0]  right_v;

  always_comb begin
    amt      = '0;
    left_v   = '0;
    right_v  = '0;
    mag_o    = '0;
    guard_o  = 1'b0;
    sticky_o = 1'b0;
    lost_o   = 1'b0;
    if (!sh_i[SHW-1]) begin
      amt = sh_i;
      if (32'(amt) >= OW) begin
        lost_o = |mag_i;
      end else begin
        left_v = {{OW{1'b0}}, mag_i} << amt;
        mag_o  = left_v[OW-1:0];
        lost_o = |left_v[LW-1:OW];
      end
    end else begin
      amt = -sh_i;
      // The IW+1 zero bits below the input hold guard and sticky after the shift.
      if (32'(amt) > IW + 1) begin
        sticky_o = |mag_i;
      end else begin
        right_v  = {mag_i, {(IW+1){1'b0}}} >> amt;
        mag_o    = OW'(right_v[RW-1:IW+1]);
        guard_o  = right_v[IW];
        sticky_o = |right_v[IW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/float_to_fixed_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | float_to_fixed_pipe : 3-stage IEEE-754 to signed fixed-point       |
// | converter with rounding, saturation and flags.      Revision: 1.0  |
// +--------------------------------------------------------------------+
module float_to_fixed_pipe
  import fx_conv_pkg::*;
#(
  parameter int EW   = 8,
  parameter int MW   = 23,
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [EW+MW:0] float_i,
  input  logic           rnd_mode_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [W-1:0]   fixed_o,
  output logic [3:0]     flags_o
);

  localparam int SHW    = EW + 2;
  localparam int SH_OFF = FRAC - MW - fp_bias(EW);
  localparam logic signed [SHW-1:0] C_SH_OFF = SHW'(SH_OFF);
  localparam logic signed [SHW-1:0] C_SH_MAX = SHW'(W - 1 - MW);
  localparam logic [W+1:0] C_POS_LIM = {2'b00, 1'b0, {(W-1){1'b1}}};
  localparam logic [W+1:0] C_NEG_LIM = {2'b00, 1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] C_MAX     = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] C_MIN     = {1'b1, {(W-1){1'b0}}};

  logic adv;

  logic                  s1_valid_q, s1_sign_q, s1_rnd_q;
  logic [MW:0]           s1_man_q;
  logic signed [SHW-1:0] s1_sh_q;
  fp_class_e             s1_cls_q;

  logic                  s2_valid_q, s2_sign_q, s2_rnd_q;
  logic                  s2_guard_q, s2_sticky_q, s2_ovf_q;
  logic [W:0]            s2_mag_q;
  fp_class_e             s2_cls_q;

  logic                  out_valid_q;
  logic [W-1:0]          fixed_q;
  logic [3:0]            flags_q;

  logic [EW-1:0]         exp_f;
  logic [MW-1:0]         man_f;
  fp_class_e             cls_d;
  logic signed [SHW-1:0] sh_d;

  logic [W:0]            mag_d;
  logic                  guard_d, sticky_d, lost_d, ovf_pre_d;

  logic                  inc;
  logic [W+1:0]          mag_r;
  logic                  ovf_r;
  logic [W-1:0]          fixed_d;
  logic [3:0]            flags_d;

  assign adv         = !out_valid_q || out_ready_i;
  assign in_ready_o  = adv;
  assign out_valid_o = out_valid_q;
  assign fixed_o     = fixed_q;
  assign flags_o     = flags_q;

  always_comb begin
    exp_f = float_i[EW+MW-1:MW];
    man_f = float_i[MW-1:0];
    sh_d  = $signed({2'b00, exp_f}) + C_SH_OFF;
    if (exp_f == '0)
      cls_d = (man_f == '0) ? CLS_ZERO : CLS_DENORM;
    else if (exp_f == '1)
      cls_d = (man_f == '0) ? CLS_INF : CLS_NAN;
    else
      cls_d = CLS_NORMAL;
  end

  fx_align_shifter #(
    .IW  (MW + 1),
    .OW  (W + 1),
    .SHW (SHW)
  ) u_align (
    .mag_i    (s1_man_q),
    .sh_i     (s1_sh_q),
    .mag_o    (mag_d),
    .guard_o  (guard_d),
    .sticky_o (sticky_d),
    .lost_o   (lost_d)
  );

  assign ovf_pre_d = lost_d || (!s1_sh_q[SHW-1] && (s1_sh_q > C_SH_MAX));

  always_comb begin
    inc     = (s2_rnd_q == RND_RNE) && s2_guard_q && (s2_sticky_q || s2_mag_q[0]);
    mag_r   = {1'b0, s2_mag_q} + (W+2)'(inc);
    // A negative result may reach one step further than a positive one.
    ovf_r   = s2_ovf_q || (s2_sign_q ? (mag_r > C_NEG_LIM) : (mag_r > C_POS_LIM));
    fixed_d = '0;
    flags_d = '0;
    case (s2_cls_q)
      CLS_NAN: flags_d[FLAG_INV] = 1'b1;
      CLS_INF: begin
        fixed_d            = s2_sign_q ? C_MIN : C_MAX;
        flags_d[FLAG_OVF]  = 1'b1;
      end
      CLS_DENORM: begin
        flags_d[FLAG_UNF]  = 1'b1;
        flags_d[FLAG_INX]  = 1'b1;
      end
      CLS_NORMAL: begin
        flags_d[FLAG_INX]  = s2_guard_q || s2_sticky_q;
        if (ovf_r) begin
          fixed_d           = s2_sign_q ? C_MIN : C_MAX;
          flags_d[FLAG_OVF] = 1'b1;
        end else begin
          fixed_d           = s2_sign_q ? -mag_r[W-1:0] : mag_r[W-1:0];
          flags_d[FLAG_UNF] = (mag_r == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_rnd_q    <= 1'b0;
      s1_man_q    <= '0;
      s1_sh_q     <= '0;
      s1_cls_q    <= CLS_ZERO;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_rnd_q    <= 1'b0;
      s2_guard_q  <= 1'b0;
      s2_sticky_q <= 1'b0;
      s2_ovf_q    <= 1'b0;
      s2_mag_q    <= '0;
      s2_cls_q    <= CLS_ZERO;
      out_valid_q <= 1'b0;
      fixed_q     <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid_i;
      if (in_valid_i) begin
        s1_sign_q <= float_i[EW+MW];
        s1_rnd_q  <= rnd_mode_i;
        s1_man_q  <= {1'b1, float_i[MW-1:0]};
        s1_sh_q   <= sh_d;
        s1_cls_q  <= cls_d;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_q   <= s1_sign_q;
        s2_rnd_q    <= s1_rnd_q;
        s2_guard_q  <= guard_d;
        s2_sticky_q <= sticky_d;
        s2_ovf_q    <= ovf_pre_d;
        s2_mag_q    <= mag_d;
        s2_cls_q    <= s1_cls_q;
      end
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        fixed_q <= fixed_d;
        flags_q <= flags_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_float_to_fixed_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_float_to_fixed_pipe : directed and streaming checks of the      |
// | float-to-fixed pipeline.                            Revision: 1.0  |
// +--------------------------------------------------------------------+
module tb_float_to_fixed_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, rnd_mode, out_valid, out_ready;
  logic [31:0] float_v, fixed_v;
  logic [3:0]  flags_v;

  typedef struct {
    logic [31:0] fixed;
    logic [3:0]  flags;
    int          cyc;
    logic        chk_lat;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  int          cyc      = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] held_fixed;
  logic [3:0]  held_flags;

  always #5 clk = ~clk;

  float_to_fixed_pipe #(.EW(8), .MW(23), .W(32), .FRAC(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .float_i     (float_v),
    .rnd_mode_i  (rnd_mode),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .fixed_o     (fixed_v),
    .flags_o     (flags_v)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent reference: integer quotient/remainder against a half-ulp.
  function automatic logic [35:0] ref_model(input logic [31:0] f, input logic rm);
    logic              s, up, inx, ovf;
    int                e, x, r;
    longint unsigned   mant, mag, qv, rem, half;
    logic [31:0]       res;
    s    = f[31];
    e    = int'(f[30:23]);
    mant = {40'd0, 1'b1, f[22:0]};
    up   = 1'b0;
    inx  = 1'b0;
    if (e == 255)
      return (f[22:0] != 0) ? {4'h8, 32'h0} : {4'h4, (s ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    if (e == 0)
      return (f[22:0] != 0) ? {4'h3, 32'h0} : 36'h0;
    x = e - 127 + 16 - 23;
    if (x >= 0) begin
      mag = (x > 40) ? 64'hFFFF_FFFF_FFFF : (mant << x);
    end else begin
      r = -x;
      if (r > 40) begin
        qv  = 0;
        rem = mant;
      end else begin
        qv   = mant >> r;
        rem  = mant - (qv << r);
        half = 64'd1 << (r - 1);
        up   = rm && ((rem > half) || ((rem == half) && qv[0]));
      end
      inx = (rem != 0);
      mag = qv + {63'd0, up};
    end
    ovf = s ? (mag > 64'h8000_0000) : (mag > 64'h7FFF_FFFF);
    if (ovf)
      return {2'b01, 1'b0, inx, (s ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    res = s ? -mag[31:0] : mag[31:0];
    return {2'b00, (mag == 0), inx, res};
  endfunction

  function automatic logic [31:0] rand_float();
    int         sel;
    logic [7:0] e;
    sel = $urandom_range(0, 15);
    if (sel == 0)      e = 8'd0;
    else if (sel == 1) e = 8'd255;
    else               e = 8'($urandom_range(100, 150));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic cycle(input logic iv, input logic [31:0] f, input logic rm, input logic ordy,
                       input logic [35:0] ev, input logic lat);
    exp_t e;
    @(negedge clk);
    cyc++;
    if (stall_prev) begin
      check_eq("stall_valid", 64'(out_valid), 64'd1);
      check_eq("stall_fixed", 64'(fixed_v), 64'(held_fixed));
      check_eq("stall_flags", 64'(flags_v), 64'(held_flags));
    end
    in_valid  = iv;
    float_v   = f;
    rnd_mode  = rm;
    out_ready = ordy;
    #1;
    stall_prev = out_valid && !out_ready;
    held_fixed = fixed_v;
    held_flags = flags_v;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check_eq("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        e = q.pop_front();
        check_eq("fixed", 64'(fixed_v), 64'(e.fixed));
        check_eq("flags", 64'(flags_v), 64'(e.flags));
        if (e.chk_lat) check_eq("latency", 64'(cyc - e.cyc), 64'd3);
      end
    end
    if (iv && in_ready) begin
      e.fixed   = ev[31:0];
      e.flags   = ev[35:32];
      e.cyc     = cyc;
      e.chk_lat = lat;
      q.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && q.size() > 0; k++)
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 36'h0, 1'b0);
    check_eq("drain_left", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  task automatic run_vec(input logic [31:0] f, input logic rm, input logic [31:0] fx, input logic [3:0] fl);
    cycle(1'b1, f, rm, 1'b1, {fl, fx}, 1'b1);
    drain(10);
  endtask

  initial begin
    logic [31:0] f;
    logic        rm;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    float_v   = 32'h0;
    rnd_mode  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_fixed", 64'(fixed_v), 64'd0);
    check_eq("rst_flags", 64'(flags_v), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors with hand-computed results
    run_vec(32'h3FC0_0000, 1'b0, 32'h0001_8000, 4'h0);
    run_vec(32'hC010_0000, 1'b0, 32'hFFFD_C000, 4'h0);
    run_vec(32'h37C0_0000, 1'b0, 32'h0000_0001, 4'h1);
    run_vec(32'h37C0_0000, 1'b1, 32'h0000_0002, 4'h1);
    run_vec(32'h3700_0000, 1'b1, 32'h0000_0000, 4'h3);
    run_vec(32'h3820_0000, 1'b1, 32'h0000_0002, 4'h1);
    run_vec(32'hB7C0_0000, 1'b0, 32'hFFFF_FFFF, 4'h1);
    run_vec(32'h3F80_0000, 1'b1, 32'h0001_0000, 4'h0);
    run_vec(32'h4980_0000, 1'b0, 32'h7FFF_FFFF, 4'h4);
    run_vec(32'h4700_0000, 1'b0, 32'h7FFF_FFFF, 4'h4);
    run_vec(32'hC700_0000, 1'b0, 32'h8000_0000, 4'h0);
    run_vec(32'hFF80_0000, 1'b0, 32'h8000_0000, 4'h4);
    run_vec(32'h7FC0_0000, 1'b0, 32'h0000_0000, 4'h8);
    run_vec(32'h8000_0000, 1'b0, 32'h0000_0000, 4'h0);
    run_vec(32'h0000_0001, 1'b0, 32'h0000_0000, 4'h3);

    // Streaming with random backpressure
    for (int k = 0; k < 100; k++) begin
      f  = rand_float();
      rm = 1'($urandom_range(0, 1));
      cycle(1'b1, f, rm, 1'($urandom_range(0, 1)), ref_model(f, rm), 1'b0);
    end
    drain(300);

    // Reset with words in flight, first word stalled at the output
    cycle(1'b1, 32'h3FC0_0000, 1'b0, 1'b1, 36'h0_0001_8000, 1'b0);
    cycle(1'b1, 32'hC010_0000, 1'b0, 1'b1, 36'h0_FFFD_C000, 1'b0);
    cycle(1'b1, 32'h3F80_0000, 1'b0, 1'b1, 36'h0_0001_0000, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 36'h0, 1'b0);
    check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 64'(out_valid), 64'd0);
    check_eq("async_rst_fixed", 64'(fixed_v), 64'd0);
    check_eq("async_rst_flags", 64'(flags_v), 64'd0);
    q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
    run_vec(32'hC010_0000, 1'b0, 32'hFFFD_C000, 4'h0);

    // Back-to-back with the consumer always ready
    for (int k = 0; k < 20; k++) begin
      f  = rand_float();
      rm = 1'($urandom_range(0, 1));
      cycle(1'b1, f, rm, 1'b1, ref_model(f, rm), 1'b1);
      check_eq("b2b_in_ready", 64'(in_ready), 64'd1);
      if (k >= 3) check_eq("b2b_out_valid", 64'(out_valid), 64'd1);
    end
    drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/float_to_fixed_pipe.md
# float_to_fixed_pipe

Parametrised, pipelined IEEE-754 to signed fixed-point converter with valid/ready flow control, selectable rounding, saturation and exception flags. It takes one packed float per cycle and returns a two's-complement fixed-point word with a programmable binary-point position after a fixed 3-cycle latency. It sits between the float-producing datapath and the fixed-point consumers, and is the pipelined, width-generic successor of the single-shot float-to-fixed converter.

## Interface
- EW, 8, exponent width; bias = 2^(EW-1)-1
- MW, 23, stored mantissa width; input width SW = 1+EW+MW
- W, 32, output width, signed two's complement
- FRAC, 16, number of fractional bits in output (0 ≤ FRAC < W)
- CLK  in  1  clock, rising edge
- RST  in  1  reset; one clock; reset is asynchronous and active-low
- IN_VALID  in  1  input word valid
- IN_READY  out  1  block accepts input this cycle
- FLOAT  in  SW  {sign, exponent, mantissa}
- RND_MODE  in  1  0 = truncate toward zero, 1 = round-to-nearest-even; sampled with FLOAT
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  consumer accepts result
- FIXED  out  W  result
- FLAGS  out  4  {INV, OVF, UNF, INX}, aligned with FIXED

## Operation
- Value = (-1)^s · 1.m · 2^(e-bias), scaled by 2^FRAC. Signed shift SH = (e - bias) + FRAC - MW, computed at EW+2 bits.
- Stage 1 (unpack/classify): register s, {1,m}, SH, RND_MODE, class (zero, denormal, normal, inf, NaN).
- Stage 2 (align): SH ≥ 0: left-shift the magnitude into a W+1-bit field; set ovf_pre if SH > W-1-MW or any bit is lost. SH < 0: right-shift by -SH, keep guard bit and sticky (OR of the rest). -SH > MW+1 gives magnitude 0, guard 0 for -SH > MW+2, sticky = 1.
- Stage 3 (round/saturate/sign): RNE increments when guard & (sticky | lsb). Truncate never increments. Then negate if s. Limits are +2^(W-1)-1 and -2^(W-1); out of range saturates to 0x7FF..F or 0x800..0 and sets OVF.
- Special inputs:
  - NaN: FIXED = 0, INV = 1.
  - ±Inf: saturate to the signed limit, OVF = 1.
  - ±0: FIXED = 0, no flags.
  - Denormal: flushed to 0, UNF = 1, INX = 1.
- INX is set when guard | sticky is nonzero, or on a denormal flush. UNF is set when the nonzero input gives a final 0 result.
- -0.0 yields 0x000..0, never a negative zero.

## Timing
- Latency: 3 cycles from the accepting edge (IN_VALID & IN_READY) to OUT_VALID, with no stalls.
- Throughput: 1 result per cycle while OUT_READY = 1.
- Global advance: adv = !OUT_VALID | OUT_READY. IN_READY = adv. All stage registers load only when adv is high.
- Each stage holds a valid bit. Bubbles propagate as valid = 0.
- Under backpressure (OUT_VALID & !OUT_READY), every stage holds. FIXED and FLAGS stay stable and no input is taken.
- The same-cycle handshake on input and output is legal and loses no data.
- Reset (RST low, any time, including mid-stream): all stage valids clear immediately, OUT_VALID = 0, FIXED = 0, FLAGS = 0. IN_READY = 1 once reset is released. In-flight words are discarded.
- FIXED and FLAGS are registered outputs. No combinational path runs from FLOAT to any output. The only combinational input-to-output path is OUT_READY to IN_READY.

## Structure
- Shared package `fx_conv_pkg`:
  - class enum (ZERO, DENORM, NORMAL, INF, NAN)
  - flag bit indices
  - RND_TRUNC/RND_RNE constants
  - bias function of EW
- One natural sub-module: `fx_align_shifter`, the bidirectional shifter of stage 2. It is parametrised by input width, output width and shift width, and returns the shifted value plus guard, sticky and lost-bits outputs.
- Pipeline control, classification and round/saturate stay in the top.

## Test plan
All cases use defaults (EW=8, MW=23, W=32, FRAC=16).
- 0x3FC00000 (1.5), RND_MODE=0 → FIXED 0x00018000, FLAGS 0. Then 0xC0100000 (-2.25) → 0xFFFDC000, FLAGS 0.
- Rounding ties:
  - 0x37C00000 (1.5·2^-16): truncate → 0x00000001, INX; RNE → 0x00000002, INX.
  - 0x37000000 (2^-17): RNE → 0x00000000, UNF|INX.
- Saturation and specials:
  - 0x49800000 (2^20) → 0x7FFFFFFF, OVF.
  - 0xFF800000 (-Inf) → 0x80000000, OVF.
  - 0x7FC00000 (NaN) → 0x00000000, INV.
  - 0x80000000 (-0) → 0x00000000, FLAGS 0.
- Streaming 100 random floats with IN_VALID always high and random OUT_READY stalls (50%) → results match the reference model in order, no drops or duplicates, and FIXED holds stable during every stall.
- RST asserted low for 1 cycle while 3 words are in flight → OUT_VALID = 0 and FIXED = 0 asynchronously. After release, the first new input appears exactly 3 accepted cycles later and no stale word is emitted.
- Back-to-back input with OUT_READY tied high → OUT_VALID stays high continuously from cycle 3 onward, and IN_READY never drops.
